// File: rtl/sm_xram_pkg.sv
// Shared definitions for the schoolMIPS exchange-memory arbiter: FSM states and default widths.
package sm_xram_pkg;

  localparam int XRAM_N_PORTS    = 4;
  localparam int XRAM_DATA_WIDTH = 32;
  localparam int XRAM_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    XS_IDLE   = 2'd0,
    XS_ACCESS = 2'd1,
    XS_DONE   = 2'd2
  } xramState_t;

endpackage

// File: rtl/sm_xram_storage.sv
// Word array with one synchronous write port, an async read port and an async debug read port.
module sm_xram_storage
  import sm_xram_pkg::*;
#(
  parameter int DATA_WIDTH = XRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = XRAM_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_wd,
  output logic [DATA_WIDTH-1:0] o_rd,
  input  logic [ADDR_WIDTH-1:0] i_dbg_a,
  output logic [DATA_WIDTH-1:0] o_dbg_rd
);

  // Contents are deliberately not reset; software owns initialisation.
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_a] <= i_wd;
    end
  end

  assign o_rd     = r_mem[i_a];
  assign o_dbg_rd = r_mem[i_dbg_a];

endmodule

// File: rtl/sm_xram_arbiter.sv
// Round-robin arbiter serialising core accesses to the shared exchange memory,
// one IDLE -> ACCESS -> DONE transaction at a time.
module sm_xram_arbiter
  import sm_xram_pkg::*;
#(
  parameter int N_PORTS    = XRAM_N_PORTS,
  parameter int DATA_WIDTH = XRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = XRAM_ADDR_WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [N_PORTS-1:0]              i_req,
  input  logic [N_PORTS-1:0]              i_we,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]   i_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   i_wdata,
  output logic [N_PORTS-1:0]              o_ack,
  output logic [DATA_WIDTH-1:0]           o_rdata,
  output logic                            o_busy,
  output logic [$clog2(N_PORTS)-1:0]      o_grant_id,
  input  logic [ADDR_WIDTH-1:0]           i_dbg_addr,
  output logic [DATA_WIDTH-1:0]           o_dbg_data
);

  localparam int GW = $clog2(N_PORTS);

  xramState_t              r_state;
  logic [N_PORTS-1:0]      r_ack;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_busy;
  logic [GW-1:0]           r_grant;
  logic [GW-1:0]           r_last;

  logic [ADDR_WIDTH-1:0]   w_memAddr;
  logic [DATA_WIDTH-1:0]   w_memWd;
  logic [DATA_WIDTH-1:0]   w_memRd;
  logic                    w_memWe;
  logic [GW-1:0]           w_winner;

  // First requester after the last winner, wrapping around the ports.
  function automatic logic [GW-1:0] pickWinner(input logic [N_PORTS-1:0] req,
                                               input logic [GW-1:0] last);
    logic [GW-1:0] win;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx = (int'(last) + i) % N_PORTS;
      if (!found && req[idx]) begin
        win   = idx[GW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_winner  = pickWinner(i_req, r_last);
  assign w_memAddr = i_addr[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_memWd   = i_wdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign w_memWe   = (r_state == XS_ACCESS) && i_we[r_grant];

  sm_xram_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_storage (
    .i_clk   (i_clk),
    .i_we    (w_memWe),
    .i_a     (w_memAddr),
    .i_wd    (w_memWd),
    .o_rd    (w_memRd),
    .i_dbg_a (i_dbg_addr),
    .o_dbg_rd(o_dbg_data)
  );

  // Pointer resets to the last port so port 0 is searched first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= XS_IDLE;
      r_ack   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_grant <= '0;
      r_last  <= GW'(N_PORTS - 1);
    end else begin
      case (r_state)
        XS_IDLE: begin
          r_ack <= '0;
          if (|i_req) begin
            r_grant <= w_winner;
            r_last  <= w_winner;
            r_busy  <= 1'b1;
            r_state <= XS_ACCESS;
          end
        end
        XS_ACCESS: begin
          r_ack <= N_PORTS'(1) << r_grant;
          if (!i_we[r_grant]) begin
            r_rdata <= w_memRd;
          end
          r_state <= XS_DONE;
        end
        XS_DONE: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= XS_IDLE;
        end
        default: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= XS_IDLE;
        end
      endcase
    end
  end

  assign o_ack      = r_ack;
  assign o_rdata    = r_rdata;
  assign o_busy     = r_busy;
  assign o_grant_id = r_grant;

endmodule

// File: tb/tb_sm_xram_arbiter.sv
// Self-checking bench for sm_xram_arbiter: directed scenarios plus random requesters
// compared every cycle against a transaction-timeline model of the arbiter.
module tb_sm_xram_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int GW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NP-1:0]  req;
  logic [NP-1:0]  we;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP-1:0]  ack;
  logic [DW-1:0]  rdata;
  logic           busy;
  logic [GW-1:0]  grantId;
  logic [AW-1:0]  dbgAddr;
  logic [DW-1:0]  dbgData;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  sm_xram_arbiter #(
    .N_PORTS(NP),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_we      (we),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_ack     (ack),
    .o_rdata   (rdata),
    .o_busy    (busy),
    .o_grant_id(grantId),
    .i_dbg_addr(dbgAddr),
    .o_dbg_data(dbgData)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Model: each grant at edge g yields ack after edge g+1, busy through g+1, next arbitration at g+3.
  logic [DW-1:0] mMem [16];
  bit            mKnown [16];
  int            mLast;
  bit            mPending;
  longint        mEdge;
  longint        mGrantEdge;
  logic [NP-1:0] expAck;
  logic [DW-1:0] expRdata;
  bit            expRdataValid;
  bit            expBusy;
  int            expGrant;

  initial begin
    for (int i = 0; i < 16; i++) mKnown[i] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPending = 0; mLast = NP - 1; mEdge = 0; mGrantEdge = 0;
      expAck = '0; expRdata = '0; expRdataValid = 1; expBusy = 0; expGrant = 0;
    end else begin
      int a;
      mEdge++;
      if (mPending && mEdge == mGrantEdge + 1) begin
        a = int'(addr[expGrant*AW +: AW]);
        if (we[expGrant]) begin
          mMem[a] = wdata[expGrant*DW +: DW];
          mKnown[a] = 1;
        end else begin
          expRdata = mMem[a];
          expRdataValid = mKnown[a];
        end
      end
      if (mPending && mEdge >= mGrantEdge + 3) mPending = 0;
      if (!mPending && req != '0) begin
        for (int k = 1; k <= NP; k++) begin
          int p;
          p = (mLast + k) % NP;
          if (req[p]) begin
            expGrant = p;
            break;
          end
        end
        mLast = expGrant;
        mGrantEdge = mEdge;
        mPending = 1;
      end
      expAck  = (mPending && mEdge == mGrantEdge + 1) ? (NP'(1) << expGrant) : '0;
      expBusy = mPending && (mEdge - mGrantEdge) < 2;
    end
  end

  always @(negedge clk) begin
    checkOutput("ack", 32'(ack), 32'(expAck));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("grant_id", 32'(grantId), 32'(expGrant));
    if (expRdataValid) checkOutput("rdata", rdata, expRdata);
    if (mKnown[dbgAddr]) checkOutput("dbg_data", dbgData, mMem[dbgAddr]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setPort(input int p, input bit r, input bit w, input int a, input logic [31:0] d);
    req[p] = r;
    we[p]  = w;
    addr[p*AW +: AW]  = a[AW-1:0];
    wdata[p*DW +: DW] = d;
  endtask

  task automatic waitAck(input int p, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!ack[p] && cycles < 20);
    if (!ack[p]) checkOutput($sformatf("ack%0d timeout", p), 32'(ack), 32'(1) << p);
  endtask

  task automatic waitAnyAck(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (ack == '0 && cycles < 20);
    if (ack == '0) checkOutput("anyAck timeout", 32'(ack), 32'hF);
  endtask

  // Random requesters that follow the hold-until-ack rule, with occasional in-flight data changes.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (req[p] && ack[p]) begin
          if ($urandom_range(1, 0) == 1)
            setPort(p, 1, 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), $urandom);
          else
            req[p] = 1'b0;
        end else if (!req[p] && $urandom_range(3, 0) == 0) begin
          setPort(p, 1, 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), $urandom);
        end else if (req[p] && $urandom_range(15, 0) == 0) begin
          addr[p*AW +: AW]  = 4'($urandom_range(15, 0));
          wdata[p*DW +: DW] = $urandom;
        end
      end
      dbgAddr = 4'($urandom_range(15, 0));
      tick();
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] prev;
    rst_n = 0; req = '0; we = '0; addr = '0; wdata = '0; dbgAddr = '0;
    req = 4'b1011; we = 4'b1111;
    repeat (3) tick();
    checkOutput("rstAck", 32'(ack), 0);
    checkOutput("rstRdata", rdata, 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstGrant", 32'(grantId), 0);
    req = '0; we = '0; rst_n = 1;
    repeat (4) tick();
    checkOutput("idleAck", 32'(ack), 0);
    checkOutput("idleBusy", 32'(busy), 0);

    setPort(2, 1, 1, 5, 32'hDEADBEEF);
    waitAck(2, n);
    checkOutput("wrLatency", n, 2);
    checkOutput("wrAck", 32'(ack), 32'h4);
    setPort(2, 0, 0, 0, 0);
    setPort(0, 1, 0, 5, 0);
    waitAck(0, n);
    checkOutput("rdAck", 32'(ack), 32'h1);
    checkOutput("rdData", rdata, 32'hDEADBEEF);
    setPort(0, 0, 0, 0, 0);
    dbgAddr = 4'd5;
    #1 checkOutput("dbgData5", dbgData, 32'hDEADBEEF);

    rst_n = 0; tick(); rst_n = 1; tick();
    for (int p = 0; p < NP; p++) setPort(p, 1, 1, p, 32'h100 + p);
    for (int p = 0; p < NP; p++) begin
      waitAck(p, n);
      checkOutput($sformatf("allAck%0d", p), 32'(ack), 32'(1) << p);
      checkOutput($sformatf("allGap%0d", p), n, (p == 0) ? 2 : 3);
      setPort(p, 0, 0, 0, 0);
    end
    for (int i = 0; i < NP; i++) begin
      setPort(0, 1, 0, i, 0);
      waitAck(0, n);
      checkOutput($sformatf("readBack%0d", i), rdata, 32'h100 + i);
      setPort(0, 0, 0, 0, 0);
    end

    setPort(0, 1, 0, 1, 0);
    setPort(3, 1, 0, 2, 0);
    for (int i = 0; i < 6; i++) begin
      waitAnyAck(n);
      checkOutput($sformatf("fair%0d", i), 32'(ack), (i % 2 == 0) ? 32'h8 : 32'h1);
    end
    setPort(0, 0, 0, 0, 0);
    setPort(3, 0, 0, 0, 0);

    setPort(1, 1, 1, 7, 32'hAAAA);
    waitAck(1, n);
    setPort(1, 0, 0, 0, 0);
    tick(); tick();
    setPort(1, 1, 1, 7, 32'h1234);
    tick();
    checkOutput("midBusyPre", 32'(busy), 1);
    rst_n = 0;
    #1;
    checkOutput("midRstBusy", 32'(busy), 0);
    checkOutput("midRstAck", 32'(ack), 0);
    setPort(1, 0, 0, 0, 0);
    tick();
    dbgAddr = 4'd7;
    rst_n = 1;
    #1 checkOutput("midRstMem", dbgData, 32'hAAAA);
    tick(); tick();
    checkOutput("midRstNoAck", 32'(ack), 0);
    setPort(1, 1, 1, 7, 32'h1234);
    waitAck(1, n);
    checkOutput("retryLatency", n, 2);
    setPort(1, 0, 0, 0, 0);
    tick();
    checkOutput("retryMem", dbgData, 32'h1234);

    tick(); tick();
    setPort(1, 1, 1, 3, 32'h55);
    tick();
    setPort(2, 1, 0, 3, 0);
    prev = rdata;
    tick();
    checkOutput("qWrAck", 32'(ack), 32'h2);
    checkOutput("qRdataHeld", rdata, prev);
    setPort(1, 0, 0, 0, 0);
    waitAck(2, n);
    checkOutput("qRdAck", 32'(ack), 32'h4);
    checkOutput("qRdData", rdata, 32'h55);
    setPort(2, 0, 0, 0, 0);

    applyStimulus(800);
    req = '0;
    repeat (6) tick();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
